// File: rtl/usart_tx_frame.sv
// usart_tx_frame: USART transmit framer.
// Serialises one DATA_BITS-wide word per frame onto TxD: a start bit, then the
// data bits LSB first, an optional parity bit, and one or two stop bits.
// A one-entry holding register decouples the CPU write handshake from bit
// timing, so frames can run back to back. INClk is sampled as data on CPUClk.
// Optional feature macro: USART_TX_PARITY_EN (adds the PARITY state/logic).
module usart_tx_frame #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 CPUClk,
  input  logic                 Reset,
  input  logic                 INClk,
  input  logic [DATA_BITS-1:0] TxData,
  input  logic                 TxValid,
  output logic                 TxReady,
  input  logic [1:0]           Parity,
  input  logic                 StopBits,
  output logic                 TxD,
  output logic                 TxBusy,
  output logic                 TxDone
);

  localparam int unsigned CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef USART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;

  logic                 INClk_d;
  logic                 tick;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic [2:0]           state;
  logic [2:0]           state_nx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nx;
  logic [CW-1:0]        bit_cnt;
  logic [CW-1:0]        cnt_nx;
  logic                 stop2_q;
  logic                 xfer;
  logic                 frame_end;
  logic                 txd_nx;

`ifdef USART_TX_PARITY_EN
  logic                 par_en_q;
  logic                 par_bit_q;
`else
  logic                 unused_parity;
  assign unused_parity = ^Parity;
`endif

  assign tick    = INClk & ~INClk_d;
  assign TxReady = ~hold_full;
  assign TxBusy  = (state != ST_IDLE);

  // Next-state, shift and counter logic; all movement is gated by tick.
  // Frame end and the IDLE start share one transfer path, so a full holding
  // register goes straight to START without an idle bit.
  always_comb begin
    state_nx  = state;
    shift_nx  = shift;
    cnt_nx    = bit_cnt;
    xfer      = 1'b0;
    frame_end = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE:   xfer = hold_full;
        ST_START: begin
          state_nx = ST_DATA;
          cnt_nx   = '0;
        end
        ST_DATA: begin
          if (bit_cnt == LAST_BIT) begin
`ifdef USART_TX_PARITY_EN
            state_nx = par_en_q ? ST_PARITY : ST_STOP1;
`else
            state_nx = ST_STOP1;
`endif
          end else begin
            shift_nx = shift >> 1;
            cnt_nx   = bit_cnt + 1'b1;
          end
        end
`ifdef USART_TX_PARITY_EN
        ST_PARITY: state_nx = ST_STOP1;
`endif
        ST_STOP1: begin
          if (stop2_q) state_nx = ST_STOP2;
          else         frame_end = 1'b1;
        end
        ST_STOP2:  frame_end = 1'b1;
        default:   state_nx = ST_IDLE;
      endcase
      if (frame_end) begin
        state_nx = ST_IDLE;
        xfer     = hold_full;
      end
      if (xfer) begin
        state_nx = ST_START;
        shift_nx = hold_data;
      end
    end
  end

  // Line level for the state being entered; registered below so TxD
  // changes on the edge that closes the tick cycle.
  always_comb begin
    txd_nx = 1'b1;
    case (state_nx)
      ST_START:  txd_nx = 1'b0;
      ST_DATA:   txd_nx = shift_nx[0];
`ifdef USART_TX_PARITY_EN
      ST_PARITY: txd_nx = par_bit_q;
`endif
      default:   txd_nx = 1'b1;
    endcase
  end

  // State registers, holding register and per-frame configuration latch.
  always_ff @(posedge CPUClk) begin
    if (Reset) begin
      INClk_d   <= 1'b0;
      hold_full <= 1'b0;
      hold_data <= '0;
      state     <= ST_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      stop2_q   <= 1'b0;
      TxD       <= 1'b1;
      TxDone    <= 1'b0;
`ifdef USART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      INClk_d <= INClk;
      state   <= state_nx;
      shift   <= shift_nx;
      bit_cnt <= cnt_nx;
      TxD     <= txd_nx;
      TxDone  <= frame_end;
      if (xfer) begin
        hold_full <= 1'b0;
        stop2_q   <= StopBits;
`ifdef USART_TX_PARITY_EN
        par_en_q  <= Parity[1];
        par_bit_q <= Parity[0] ? ~^hold_data : ^hold_data;
`endif
      end else if (TxValid && TxReady) begin
        hold_full <= 1'b1;
        hold_data <= TxData;
      end
    end
  end

endmodule

// File: tb/tb_usart_tx_frame.sv
// tb_usart_tx_frame: directed bench for usart_tx_frame (DATA_BITS = 8).
// INClk toggles every 4 CPUClk cycles, so each bit lasts 8 CPUClk cycles.
// Frame patterns are hand-written: bit i of a pattern is the i-th line bit.
module tb_usart_tx_frame;

  logic       CPUClk = 1'b0;
  logic       Reset  = 1'b1;
  logic       INClk  = 1'b0;
  logic [7:0] TxData = '0;
  logic       TxValid = 1'b0;
  logic       TxReady;
  logic [1:0] Parity = 2'b00;
  logic       StopBits = 1'b0;
  logic       TxD;
  logic       TxBusy;
  logic       TxDone;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ic = 0;

  usart_tx_frame #(.DATA_BITS(8)) dut (
    .CPUClk  (CPUClk),
    .Reset   (Reset),
    .INClk   (INClk),
    .TxData  (TxData),
    .TxValid (TxValid),
    .TxReady (TxReady),
    .Parity  (Parity),
    .StopBits(StopBits),
    .TxD     (TxD),
    .TxBusy  (TxBusy),
    .TxDone  (TxDone)
  );

  always #5 CPUClk = ~CPUClk;

  // Baud clock: toggle every 4 CPUClk cycles, changed away from the active edge.
  always @(negedge CPUClk) begin
    ic = ic + 1;
    if (ic == 4) begin
      ic = 0;
      INClk = ~INClk;
    end
  end

  // Count TxDone pulses.
  always @(negedge CPUClk) begin
    if (TxDone === 1'b1) done_cnt = done_cnt + 1;
  end

  // Write one byte through the ready/valid handshake (called at a negedge).
  task automatic wr(input logic [7:0] d);
    int g = 0;
    while (TxReady !== 1'b1 && g < 200) begin
      @(negedge CPUClk);
      g++;
    end
    checks++;
    assert (TxReady === 1'b1) else begin
      errors++;
      $error("FAIL wr_ready: TxReady=%b want 1", TxReady);
    end
    TxData  = d;
    TxValid = 1'b1;
    @(negedge CPUClk);
    TxValid = 1'b0;
  endtask

  // Find the start bit, then check both ends of every bit and the end-of-frame state.
  task automatic check_frame(input string tag, input logic [15:0] pat, input int n,
                             input logic end_txd, input logic end_busy);
    int g = 0;
    while (TxD !== 1'b0 && g < 40) begin
      @(negedge CPUClk);
      g++;
    end
    checks++;
    assert (TxD === 1'b0) else begin
      errors++;
      $error("FAIL %s_start: TxD=%b want 0 (waited %0d)", tag, TxD, g);
    end
    checks++;
    assert (TxReady === 1'b1) else begin
      errors++;
      $error("FAIL %s_ready_at_start: TxReady=%b want 1", tag, TxReady);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      assert ({TxD, TxBusy} === {pat[k], 1'b1}) else begin
        errors++;
        $error("FAIL %s_bit%0d_first: TxD,TxBusy=%b%b want %b1", tag, k, TxD, TxBusy, pat[k]);
      end
      repeat (7) @(negedge CPUClk);
      checks++;
      assert ({TxD, TxBusy, TxDone} === {pat[k], 2'b10}) else begin
        errors++;
        $error("FAIL %s_bit%0d_last: TxD,TxBusy,TxDone=%b%b%b want %b10",
               tag, k, TxD, TxBusy, TxDone, pat[k]);
      end
      @(negedge CPUClk);
    end
    checks++;
    assert ({TxD, TxBusy, TxDone} === {end_txd, end_busy, 1'b1}) else begin
      errors++;
      $error("FAIL %s_end: TxD,TxBusy,TxDone=%b%b%b want %b%b1",
             tag, TxD, TxBusy, TxDone, end_txd, end_busy);
    end
  endtask

  initial begin
    int lows;
    int g;

    // Reset and idle behaviour with INClk running.
    repeat (3) @(negedge CPUClk);
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge CPUClk);
      checks++;
      assert ({TxD, TxReady, TxBusy, TxDone} === 4'b1100) else begin
        errors++;
        $error("FAIL idle_%0d: TxD,TxReady,TxBusy,TxDone=%b%b%b%b want 1100",
               i, TxD, TxReady, TxBusy, TxDone);
      end
    end
    checks++;
    assert (done_cnt === 0) else begin
      errors++;
      $error("FAIL idle_done: count=%0d want 0", done_cnt);
    end

    // 0x55, 8N1.
    wr(8'h55);
    checks++;
    assert (TxReady === 1'b0) else begin
      errors++;
      $error("FAIL accept_55: TxReady=%b want 0", TxReady);
    end
    check_frame("f55", 16'h02AA, 10, 1'b1, 1'b0);

    // 0x03, two stop bits, even then odd parity (parity bit only with the macro).
    StopBits = 1'b1;
    Parity   = 2'b10;
    wr(8'h03);
`ifdef USART_TX_PARITY_EN
    check_frame("f03_even", 16'h0C06, 12, 1'b1, 1'b0);
`else
    check_frame("f03_even", 16'h0606, 11, 1'b1, 1'b0);
`endif
    Parity = 2'b11;
    wr(8'h03);
`ifdef USART_TX_PARITY_EN
    check_frame("f03_odd", 16'h0E06, 12, 1'b1, 1'b0);
`else
    check_frame("f03_odd", 16'h0606, 11, 1'b1, 1'b0);
`endif

    // Back-to-back: 0xA5, then 0x3C queued during the 0xA5 frame.
    StopBits = 1'b0;
    Parity   = 2'b00;
    wr(8'hA5);
    checks++;
    assert (TxReady === 1'b0) else begin
      errors++;
      $error("FAIL accept_A5: TxReady=%b want 0", TxReady);
    end
    fork
      begin
        repeat (30) @(negedge CPUClk);
        wr(8'h3C);
      end
    join_none
    check_frame("fA5", 16'h034A, 10, 1'b0, 1'b1);
    check_frame("f3C", 16'h0278, 10, 1'b1, 1'b0);

    // Reset during data bit 3 of 0xFF with a byte pending in the holding register.
    wr(8'hFF);
    g = 0;
    while (TxD !== 1'b0 && g < 40) begin
      @(negedge CPUClk);
      g++;
    end
    checks++;
    assert (TxD === 1'b0) else begin
      errors++;
      $error("FAIL fFF_start: TxD=%b want 0", TxD);
    end
    wr(8'h12);
    repeat (33) @(negedge CPUClk);
    Reset = 1'b1;
    @(negedge CPUClk);
    checks++;
    assert ({TxD, TxReady, TxBusy} === 3'b110) else begin
      errors++;
      $error("FAIL reset_mid: TxD,TxReady,TxBusy=%b%b%b want 110", TxD, TxReady, TxBusy);
    end
    Reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CPUClk);
      if (TxD !== 1'b1 || TxBusy !== 1'b0) lows++;
    end
    checks++;
    assert (lows === 0) else begin
      errors++;
      $error("FAIL reset_stale: active cycles=%0d want 0", lows);
    end
    checks++;
    assert (done_cnt === 5) else begin
      errors++;
      $error("FAIL reset_done: count=%0d want 5", done_cnt);
    end

    // StopBits changed mid-frame: current frame keeps 1 stop bit, next uses 2.
    StopBits = 1'b0;
    wr(8'h55);
    fork
      begin
        repeat (30) @(negedge CPUClk);
        StopBits = 1'b1;
        wr(8'h0F);
      end
    join_none
    check_frame("f55_s1", 16'h02AA, 10, 1'b0, 1'b1);
    check_frame("f0F_s2", 16'h061E, 11, 1'b1, 1'b0);

    repeat (4) @(negedge CPUClk);
    checks++;
    assert (done_cnt === 7) else begin
      errors++;
      $error("FAIL done_total: count=%0d want 7", done_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
